// File: rtl/vx_elastic_buffer.sv
// vx_elastic_buffer
//   Elastic buffer for a valid/ready stream with configurable depth. Absorbs
//   several cycles of downstream backpressure and cuts every combinational
//   path between the upstream and downstream handshakes. It reports occupancy
//   and an almost-full flag, and it supports a synchronous flush.
//
// Parameters
//   DATAW    payload width in bits (>=1)
//   SIZE     storage depth in entries (power of two, >=2)
//   ALM_FULL alm_full threshold, 1..SIZE
//   PASSTHRU 1 = wires only; clk, reset and flush are ignored
//   SIZEW    width of the size output
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset (clears pointers and count)
//   flush      synchronous clear of all buffered entries (wins over push/pop)
//   valid_in   upstream valid
//   ready_in   upstream ready (space available)
//   data_in    upstream payload
//   valid_out  downstream valid (buffer not empty)
//   ready_out  downstream ready
//   data_out   payload at head of buffer
//   size       current occupancy, 0..SIZE
//   alm_full   occupancy >= ALM_FULL
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. The producer holds valid/data stable until the transfer. valid_out,
// data_out and ready_in come from registers only. They never depend
// combinationally on valid_in, data_in or ready_out.
module vx_elastic_buffer #(
    parameter int DATAW    = 1,
    parameter int SIZE     = 4,
    parameter int ALM_FULL = SIZE - 1,
    parameter int PASSTHRU = 0,
    parameter int SIZEW    = $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out,
    output logic [SIZEW-1:0] size,
    output logic             alm_full
);

    if (PASSTHRU != 0) begin : g_passthru

        logic unused_ok;
        assign unused_ok = &{1'b0, clk, reset, flush};

        assign valid_out = valid_in;
        assign data_out  = data_in;
        assign ready_in  = ready_out;
        assign size      = '0;
        assign alm_full  = 1'b0;

    end else begin : g_buffer

        localparam int ADDRW = $clog2(SIZE);

        logic [DATAW-1:0] mem [SIZE];
        logic [ADDRW-1:0] wr_ptr;
        logic [ADDRW-1:0] rd_ptr;
        logic [SIZEW-1:0] count;
        logic             push;
        logic             pop;

        assign push = valid_in && ready_in;
        assign pop  = valid_out && ready_out;

        // Pointers wrap naturally because SIZE is a power of two.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ADDRW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDRW'(1);
                end
                if (push && !pop) begin
                    count <= count + SIZEW'(1);
                end else if (pop && !push) begin
                    count <= count - SIZEW'(1);
                end
            end
        end

        // Storage is not reset. A push that coincides with flush is dropped.
        always_ff @(posedge clk) begin
            if (push && !flush) begin
                mem[wr_ptr] <= data_in;
            end
        end

        assign ready_in  = (count != SIZEW'(SIZE));
        assign valid_out = (count != '0);
        assign data_out  = mem[rd_ptr];
        assign size      = count;
        assign alm_full  = (count >= SIZEW'(ALM_FULL));

        a_no_push_full : assert property (
            @(posedge clk) disable iff (reset) !(push && count == SIZEW'(SIZE)));
        a_no_pop_empty : assert property (
            @(posedge clk) disable iff (reset) !(pop && count == '0));

    end

endmodule

// File: tb/tb_vx_elastic_buffer.sv
// tb_vx_elastic_buffer
//   Directed checks on a SIZE=4 / DATAW=8 instance: reset values, fill/drain,
//   full with a simultaneous pop, streaming with wrap, flush and asynchronous
//   reset. A SIZE=8 / ALM_FULL=6 instance gets randomised backpressure against
//   a queue model.
module tb_vx_elastic_buffer;

    logic clk;
    logic reset;

    // instance A: SIZE=4, DATAW=8, ALM_FULL=3
    logic       a_flush;
    logic       a_valid_in;
    logic       a_ready_in;
    logic [7:0] a_data_in;
    logic       a_valid_out;
    logic       a_ready_out;
    logic [7:0] a_data_out;
    logic [2:0] a_size;
    logic       a_alm_full;

    // instance B: SIZE=8, DATAW=8, ALM_FULL=6
    logic       b_flush;
    logic       b_valid_in;
    logic       b_ready_in;
    logic [7:0] b_data_in;
    logic       b_valid_out;
    logic       b_ready_out;
    logic [7:0] b_data_out;
    logic [3:0] b_size;
    logic       b_alm_full;

    int n_checks;
    int n_pass;

    logic [7:0] exp_q[$];

    vx_elastic_buffer #(.DATAW(8), .SIZE(4)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (a_flush),
        .valid_in  (a_valid_in),
        .ready_in  (a_ready_in),
        .data_in   (a_data_in),
        .valid_out (a_valid_out),
        .ready_out (a_ready_out),
        .data_out  (a_data_out),
        .size      (a_size),
        .alm_full  (a_alm_full)
    );

    vx_elastic_buffer #(.DATAW(8), .SIZE(8), .ALM_FULL(6)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (b_flush),
        .valid_in  (b_valid_in),
        .ready_in  (b_ready_in),
        .data_in   (b_data_in),
        .valid_out (b_valid_out),
        .ready_out (b_ready_out),
        .data_out  (b_data_out),
        .size      (b_size),
        .alm_full  (b_alm_full)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [7:0] d, input logic r, input logic f);
        a_valid_in  = v;
        a_data_in   = d;
        a_ready_out = r;
        a_flush     = f;
    endtask

    task automatic a_status(input string tag, input int sz, input logic rdy, input logic vld, input logic af);
        check({tag, ".size"},      32'(a_size),      32'(sz));
        check({tag, ".ready_in"},  32'(a_ready_in),  32'(rdy));
        check({tag, ".valid_out"}, 32'(a_valid_out), 32'(vld));
        check({tag, ".alm_full"},  32'(a_alm_full),  32'(af));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        a_drive(1'b0, 8'h00, 1'b0, 1'b0);
        b_flush     = 1'b0;
        b_valid_in  = 1'b0;
        b_data_in   = 8'h00;
        b_ready_out = 1'b0;
        repeat (3) step();

        // reset values
        a_status("reset", 0, 1'b1, 1'b0, 1'b0);
        check("reset.b_ready_in", 32'(b_ready_in), 32'd1);
        check("reset.b_size",     32'(b_size),     32'd0);
        reset = 1'b0;
        step();

        // fill with downstream stalled
        for (int i = 0; i < 4; i++) begin
            a_drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
            step();
            a_status($sformatf("fill%0d", i), i + 1, (i < 3), 1'b1, (i + 1 >= 3));
        end
        check("fill.head", 32'(a_data_out), 32'h11);

        // full with simultaneous pop: 0x55 must not be accepted
        a_drive(1'b1, 8'h55, 1'b1, 1'b0);
        step();
        a_drive(1'b0, 8'h00, 1'b1, 1'b0);
        a_status("fullpop", 3, 1'b1, 1'b1, 1'b1);
        check("drain.d1", 32'(a_data_out), 32'h22);
        step();
        a_status("drain2", 2, 1'b1, 1'b1, 1'b0);
        check("drain.d2", 32'(a_data_out), 32'h33);
        step();
        check("drain.d3", 32'(a_data_out), 32'h44);
        step();
        a_status("drained", 0, 1'b1, 1'b0, 1'b0);

        // streaming with wrap: each input appears one cycle later, size stays 1
        for (int i = 0; i < 20; i++) begin
            a_drive(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
            step();
            check($sformatf("stream%0d.data", i), 32'(a_data_out), 32'(8'hA0 + i));
            check($sformatf("stream%0d.size", i), 32'(a_size), 32'd1);
            check($sformatf("stream%0d.valid", i), 32'(a_valid_out), 32'd1);
        end
        a_drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        a_status("stream_end", 0, 1'b1, 1'b0, 1'b0);

        // flush with coincident push and pop
        for (int i = 0; i < 3; i++) begin
            a_drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
            step();
        end
        a_status("preflush", 3, 1'b1, 1'b1, 1'b1);
        a_drive(1'b1, 8'hEE, 1'b1, 1'b1);
        step();
        a_drive(1'b0, 8'h00, 1'b0, 1'b0);
        a_status("flush", 0, 1'b1, 1'b0, 1'b0);
        a_drive(1'b1, 8'h5A, 1'b0, 1'b0);
        step();
        a_drive(1'b0, 8'h00, 1'b1, 1'b0);
        a_status("postflush", 1, 1'b1, 1'b1, 1'b0);
        check("postflush.data", 32'(a_data_out), 32'h5A);
        step();
        a_status("postflush_drain", 0, 1'b1, 1'b0, 1'b0);

        // asynchronous reset between edges at size=2
        a_drive(1'b1, 8'h61, 1'b0, 1'b0);
        step();
        a_drive(1'b1, 8'h62, 1'b0, 1'b0);
        step();
        a_drive(1'b0, 8'h00, 1'b0, 1'b0);
        a_status("prereset", 2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        a_status("async_reset", 0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_drive(1'b1, 8'hAB, 1'b0, 1'b0);
        step();
        a_drive(1'b0, 8'h00, 1'b1, 1'b0);
        a_status("after_reset", 1, 1'b1, 1'b1, 1'b0);
        check("after_reset.data", 32'(a_data_out), 32'hAB);
        step();
        a_status("after_reset_drain", 0, 1'b1, 1'b0, 1'b0);

        // random backpressure on instance B against the queue model
        begin
            logic [7:0] next_d;
            logic       push_ok;
            logic       pop_ok;
            next_d = 8'h00;
            for (int c = 0; c < 400; c++) begin
                b_valid_in  = ($urandom_range(0, 3) != 0);
                b_data_in   = next_d;
                // first stretch stalls downstream more often so the buffer fills
                b_ready_out = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                push_ok = b_valid_in && (exp_q.size() != 8);
                pop_ok  = b_ready_out && (exp_q.size() != 0);
                if (pop_ok) begin
                    check($sformatf("rand%0d.data", c), 32'(b_data_out), 32'(exp_q.pop_front()));
                end
                if (push_ok) begin
                    exp_q.push_back(next_d);
                    next_d = next_d + 8'd1;
                end
                step();
                check($sformatf("rand%0d.size", c),  32'(b_size),      32'(exp_q.size()));
                check($sformatf("rand%0d.alm", c),   32'(b_alm_full),  32'(exp_q.size() >= 6));
                check($sformatf("rand%0d.ready", c), 32'(b_ready_in),  32'(exp_q.size() != 8));
                check($sformatf("rand%0d.valid", c), 32'(b_valid_out), 32'(exp_q.size() != 0));
            end
            b_valid_in  = 1'b0;
            b_ready_out = 1'b1;
            for (int c = 0; c < 12 && exp_q.size() != 0; c++) begin
                check($sformatf("rdrain%0d.data", c), 32'(b_data_out), 32'(exp_q.pop_front()));
                step();
            end
            check("rand.queue_empty", 32'(exp_q.size()), 32'd0);
            check("rand.final_valid", 32'(b_valid_out), 32'd0);
            check("rand.final_size",  32'(b_size),      32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
